// File: rtl/riscv_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, sign fix-up at FIN. Optional macro MULDIV_EARLY_OUT_EN skips RUN for trivial ops.
module riscv_muldiv_unit #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       rs2,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  stall_req
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  sa, sb, div0, ovf, mzero;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic [2*XLEN-1:0]     prod;
  logic [CW-1:0]         cnt;

  logic                  accept;
  logic                  sa_n, sb_n, div0_n, ovf_n, zero_n;
  logic [XLEN-1:0]       mag_a_n, mag_b_n;

  assign accept = (state == IDLE) & start & ~flush;

  // Operand decode: sign flags only for the signed interpretations of each op.
  always_comb begin
    sa_n    = rs1[XLEN-1] & (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    sb_n    = rs2[XLEN-1] & (op inside {3'd0, 3'd1, 3'd4, 3'd6});
    mag_a_n = sa_n ? -rs1 : rs1;
    mag_b_n = sb_n ? -rs2 : rs2;
    div0_n  = op[2] & (rs2 == '0);
    ovf_n   = op[2] & ~op[0] & (rs1 == MIN_NEG) & (rs2 == '1);
    zero_n  = ~op[2] & ((rs1 == '0) | (rs2 == '0));
  end

  // One iteration: hi half is accumulator / partial remainder, lo half multiplier / quotient.
  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     msum, shl, diff;
  logic [2*XLEN-1:0] prod_step;

  always_comb begin
    hi   = prod[2*XLEN-1:XLEN];
    lo   = prod[XLEN-1:0];
    msum = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    shl  = {hi, lo[XLEN-1]};
    diff = shl - {1'b0, mag_b};
    if (op_q[2])
      prod_step = diff[XLEN] ? {shl[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    else
      prod_step = {msum, lo[XLEN-1:1]};
  end

  // Sign fix-up and special-case overrides; early-out paths never touch prod, so overrides
  // must not depend on it.
  logic [2*XLEN-1:0] pn;
  logic [XLEN-1:0]   q_fin, r_fin, res_fin;

  always_comb begin
    pn    = (sa ^ sb) ? -prod : prod;
    q_fin = (sa ^ sb) ? -lo : lo;
    r_fin = sa ? -hi : hi;
    if (div0) begin
      q_fin = '1;
      r_fin = sa ? -mag_a : mag_a;
    end else if (ovf) begin
      q_fin = MIN_NEG;
      r_fin = '0;
    end
    if (mzero) pn = '0;
    case (op_q)
      3'd0:          res_fin = pn[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          res_fin = pn[2*XLEN-1:XLEN];
      3'd4, 3'd5:    res_fin = q_fin;
      default:       res_fin = r_fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
        state_nxt = (div0_n | ovf_n | zero_n) ? FIN : RUN;
`else
        state_nxt = RUN;
`endif
      end
      RUN:  if (flush) state_nxt = IDLE;
            else if (cnt == '0) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    stall_req = accept | (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= '0;
      rd_q   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      mzero  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      prod   <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q  <= op;
        rd_q  <= rd_in;
        sa    <= sa_n;
        sb    <= sb_n;
        div0  <= div0_n;
        ovf   <= ovf_n;
        mzero <= zero_n;
        mag_a <= mag_a_n;
        mag_b <= mag_b_n;
        prod  <= op[2] ? {{XLEN{1'b0}}, mag_a_n} : {{XLEN{1'b0}}, mag_b_n};
        cnt   <= CW'(XLEN-1);
      end else if (state == RUN && !flush) begin
        prod <= prod_step;
        cnt  <= cnt - 1'b1;
      end else if (state == FIN && !flush) begin
        result <= res_fin;
        rd_out <= rd_q;
        done   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: fixed vector table, randomized ops against a 128-bit
// arithmetic reference, and hand-written flush / held-start / reset sequences.
module tb_riscv_muldiv_unit;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, stall_req;
  logic [63:0] result;
  logic [4:0]  rd_out;

  riscv_muldiv_unit #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ubs;
    logic [127:0]        ua, ub, p;
    logic signed [63:0]  qa, qb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    ubs = ub;
    qa = a;
    qb = b;
    case (o)
      3'd0: begin p = ua * ub; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ubs; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: if (b == 0) return '1; else if (a == MINV && b == '1) return a; else return qa / qb;
      3'd5: if (b == 0) return '1; else return a / b;
      3'd6: if (b == 0) return a; else if (a == MINV && b == '1) return '0; else return qa % qb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic bit trivial(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o[2]) return (b == 0) || (!o[0] && a == MINV && b == '1);
    return (a == 0) || (b == 0);
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (trivial(o, a, b)) return 2;
`endif
    return 66;
  endfunction

  // Present a request for one cycle; returns after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] r);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd_in = r; start = 1'b1;
    #1 chk("stall_req_on_start", 64'(stall_req), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output bit got);
    lat = 0; bcnt = 0; got = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) got = 1;
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] r, input logic [63:0] exp);
    int lat, bcnt;
    bit got;
    int el;
    el = exp_lat(o, a, b);
    issue(o, a, b, r);
    wait_done(lat, bcnt, got);
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_rd_out"}, 64'(rd_out), 64'(r));
    chk({nm, "_latency"}, 64'(lat), 64'(el));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(el - 2));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [63:0] a, b;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  vec_t tv[15];
  logic [63:0] last_res;
  logic [4:0]  last_rd;

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return MINV;
      3: return 64'($urandom_range(0, 1000));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lat, bcnt, dcnt;
    bit got;
    logic [2:0]  o;
    logic [63:0] a, b, e;
    logic [4:0]  r;

    tv[0]  = '{"mul_7_m3",   3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB};
    tv[1]  = '{"mulhu_ones", 3'd3, '1, '1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    tv[2]  = '{"mulh_ones",  3'd1, '1, '1, 5'd2, 64'h0};
    tv[3]  = '{"divu_100_7", 3'd5, 64'd100, 64'd7, 5'd3, 64'hE};
    tv[4]  = '{"remu_100_7", 3'd7, 64'd100, 64'd7, 5'd4, 64'h2};
    tv[5]  = '{"div_m100_7", 3'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6, 64'hFFFF_FFFF_FFFF_FFF2};
    tv[6]  = '{"rem_m100_7", 3'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    tv[7]  = '{"div_5_0",    3'd4, 64'd5, 64'd0, 5'd8, '1};
    tv[8]  = '{"rem_5_0",    3'd6, 64'd5, 64'd0, 5'd9, 64'd5};
    tv[9]  = '{"div_ovf",    3'd4, MINV, '1, 5'd10, MINV};
    tv[10] = '{"rem_ovf",    3'd6, MINV, '1, 5'd11, 64'd0};
    tv[11] = '{"divu_5_0",   3'd5, 64'd5, 64'd0, 5'd12, '1};
    tv[12] = '{"remu_m5_0",  3'd7, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFB};
    tv[13] = '{"mulhsu_m1",  3'd2, '1, '1, 5'd14, '1};
    tv[14] = '{"mul_zero",   3'd0, 64'd0, 64'h1234, 5'd15, 64'd0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_rd_out", 64'(rd_out), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);

    foreach (tv[i]) run_op(tv[i].nm, tv[i].op, tv[i].a, tv[i].b, tv[i].rd, tv[i].exp);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      r = 5'($urandom_range(0, 31));
      e = model(o, a, b);
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, r, e);
      last_res = e;
      last_rd  = r;
    end

    // Flush mid-RUN: no done, outputs keep the previous completion.
    issue(3'd5, 64'd100, 64'd7, 5'd20);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
      end
    end
    // flush with start in IDLE must not be accepted.
    @(negedge clk);
    op = 3'd0; rs1 = 64'd3; rs2 = 64'd4; rd_in = 5'd21; start = 1'b1; flush = 1'b1;
    #1 chk("flush_start_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    dcnt = 0;
    repeat (80) begin @(negedge clk); if (done) dcnt++; end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_result_kept", result, last_res);
    chk("flush_rd_kept", 64'(rd_out), 64'(last_rd));

    // Start held during RUN is ignored.
    issue(3'd5, 64'd100, 64'd7, 5'd3);
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) got = 1;
      else begin
        if (lat == 3) begin op = 3'd0; rs1 = 64'd5; rs2 = 64'd1; rd_in = 5'd9; start = 1'b1; end
        if (lat == 60) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_done_seen", 64'(got), 64'd1);
    chk("held_latency", 64'(lat), 64'd66);
    chk("held_result", result, 64'hE);
    chk("held_rd_out", 64'(rd_out), 64'd3);
    dcnt = 0;
    repeat (70) begin @(negedge clk); if (done) dcnt++; end
    chk("held_no_extra_done", 64'(dcnt), 64'd0);
    run_op("after_held", 3'd0, 64'd9, 64'd11, 5'd22, 64'd99);

    // Synchronous reset mid-MUL aborts silently.
    issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 20) reset = 1'b0;
      if (c == 21) reset = 1'b1;
    end
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_rd_out", 64'(rd_out), 64'd0);
    dcnt = 0;
    repeat (80) begin @(negedge clk); if (done) dcnt++; end
    chk("rst_mid_no_done", 64'(dcnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Parametrised iterative multiply/divide execution unit implementing the RV64M operations. It sits beside the ALU in the EX stage of the pipelined core.
- It accepts one operation per start pulse and holds the pipeline via stall_req while iterating.
- It returns the result with rd_out and a one-cycle done pulse for the EX/MEM register to capture.
- It generalises the single-cycle ALU path to XLEN-wide multi-cycle operation, with flush support.

Parameters:
- XLEN, 64, operand/result width in bits; legal values are 32 or 64.
- REG_ADDR_W, 5, width of the destination register index.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; when low at a rising edge, all state clears.
- start  input  1  request; sampled only in IDLE.
- op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  input  XLEN  operand A (multiplicand / dividend).
- rs2  input  XLEN  operand B (multiplier / divisor).
- rd_in  input  REG_ADDR_W  destination register tag.
- flush  input  1  abort the in-flight operation (branch taken in MEM).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  XLEN  operation result; held until the next accepted start.
- rd_out  output  REG_ADDR_W  tag of the completed operation; held with result.
- stall_req  output  1  combinational: (state==IDLE & start & ~flush) | (state==RUN).

Behaviour:
- Reset: state=IDLE; busy, done, result, rd_out and all internal registers are 0. Reset dominates start and flush. Reset mid-RUN aborts with no done.
- FSM states: IDLE, RUN, FIN.
  - IDLE -> RUN when start=1 and flush=0. On that edge the unit latches op and rd_in, latches operand magnitudes with their sign flags, and loads counter=XLEN-1.
  - RUN: one iteration per cycle; counter decrements; at counter==0 -> FIN.
  - FIN: result and rd_out registered, done=1 for exactly this cycle, then -> IDLE.
- Latency: with start accepted at edge T, done is high in the cycle following edge T+XLEN+1, so the total is XLEN+2 cycles from start to done. busy is high for exactly XLEN cycles.
- Multiply: unsigned shift-add on magnitudes produces a 2*XLEN product; the sign is applied at FIN.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
  - Signedness: MULH treats both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU treats both as unsigned.
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sA xor sB.
  - Remainder sign = sign of the dividend.
- Divide by zero (rs2==0): quotient is all ones and remainder equals rs1, for both signed and unsigned ops. The unit still runs full latency.
- Signed overflow (DIV/REM with rs1 = -2^(XLEN-1) and rs2 = -1): quotient = rs1, remainder = 0.
- start while busy or in FIN is ignored; there is no queue.
- flush in RUN or FIN: next state is IDLE, busy=0, no done, and result/rd_out keep their previous values. flush together with start in IDLE: the start is not accepted.
- done never asserts without a prior accepted start.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, the unit skips RUN for:
  - divide by zero;
  - signed overflow;
  - any op where rs1==0 or rs2==0 (multiply case).
- In those cases IDLE goes directly to FIN, done is high in the cycle following edge T+1, and stall_req drops after one cycle.
- When undefined, every op takes the full XLEN+2 cycles.
- Result values are identical in both builds.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFFFFFFFFFD (-3), rd_in=5, start at T -> done at T+66, result=0xFFFFFFFFFFFFFFEB, rd_out=5; busy high for 64 cycles.
- MULHU rs1=rs2=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE. MULH with the same operands -> result=0x0.
- DIVU 100/7 -> 14 (0xE); REMU 100/7 -> 2; DIV -100/7 -> 0xFFFFFFFFFFFFFFF2 (-14); REM -100/7 -> 0xFFFFFFFFFFFFFFFE (-2).
- DIV 5/0 -> 0xFFFFFFFFFFFFFFFF; REM 5/0 -> 5; DIV 0x8000000000000000 / -1 -> 0x8000000000000000; REM of the same -> 0. With MULDIV_EARLY_OUT_EN, each of these completes with done 2 cycles after start.
- Start DIVU, then assert flush at T+10 -> busy=0 from T+11, no done pulse, result unchanged. A start held during RUN is ignored, and a new start after IDLE completes normally.
- Assert reset=0 for one cycle at T+20 of a MUL -> busy=0, done=0, result=0, rd_out=0; no spurious done afterwards.
